// File: rtl/esm_pkg.sv
// -----------------------------------------------------------------------------
// esm_pkg
// Shared types and constants for the ESM receiver status reporting path.
//
// Contents:
//   esm_channelizer_warnings_t     per-channel warning pulses (demux_gap)
//   esm_channelizer_errors_t       per-channel error pulses
//   esm_report_magic_num           first word of every report packet
//   esm_report_message_type_status message type byte for heartbeat reports
//   esm_pack_status()              folds both channels' pulses into the
//                                  12-bit status word layout
// -----------------------------------------------------------------------------
package esm_pkg;

  typedef struct packed {
    logic demux_gap;
  } esm_channelizer_warnings_t;

  typedef struct packed {
    logic demux_overflow;
    logic filter_overflow;
    logic mux_overflow;
    logic mux_underflow;
    logic mux_collision;
  } esm_channelizer_errors_t;

  localparam logic [31:0] esm_report_magic_num           = 32'hE5A5_0B0D;
  localparam logic [7:0]  esm_report_message_type_status = 8'h01;

  // Every report is a fixed-length packet.
  localparam int ESM_REPORT_WORDS = 64;

  // Number of meaningful bits in the status word.
  localparam int ESM_STATUS_BITS = 12;

  // Status word layout, LSB first:
  //   [0]    chan0 demux_gap
  //   [1]    chan1 demux_gap
  //   [6:2]  chan0 demux_overflow, filter_overflow, mux_overflow,
  //          mux_underflow, mux_collision
  //   [11:7] chan1, same order as chan0
  function automatic logic [ESM_STATUS_BITS-1:0] esm_pack_status(
    input esm_channelizer_warnings_t [1:0] warnings,
    input esm_channelizer_errors_t   [1:0] errors
  );
    return {errors[1].mux_collision,
            errors[1].mux_underflow,
            errors[1].mux_overflow,
            errors[1].filter_overflow,
            errors[1].demux_overflow,
            errors[0].mux_collision,
            errors[0].mux_underflow,
            errors[0].mux_overflow,
            errors[0].filter_overflow,
            errors[0].demux_overflow,
            warnings[1].demux_gap,
            warnings[0].demux_gap};
  endfunction

endpackage

// File: rtl/esm_status_reporter.sv
// -----------------------------------------------------------------------------
// esm_status_reporter
// Periodic heartbeat status reporter for the ESM receiver. Every
// HEARTBEAT_INTERVAL cycles it snapshots the enable inputs and the channelizer
// warning/error pulses accumulated since the previous report, and emits the
// snapshot as a fixed 64-word AXI-Stream packet.
//
// Parameters:
//   AXI_DATA_WIDTH      stream word width (only 32 is supported)
//   MODULE_ID           module_id byte placed in header word 2
//   HEARTBEAT_INTERVAL  cycles between report triggers (>= 128)
//
// Ports:
//   Clk                   clock
//   Rst                   synchronous reset, active high
//   Enable_status         report generation enable; also enables bit 0
//   Enable_channelizer    per-channel channelizer enable (level)
//   Enable_pdw_encoder    per-channel PDW encoder enable (level)
//   Channelizer_warnings  single-cycle warning pulses, per channel
//   Channelizer_errors    single-cycle error pulses, per channel
//   Axis_ready            downstream ready
//   Axis_valid            word valid
//   Axis_data             word data
//   Axis_last             last word of packet (word 63)
//
// Packet layout:
//   w0 magic, w1 sequence number, w2 {MODULE_ID, type, 16'h0}, w3 enables,
//   w4 status, w5 timestamp[63:32], w6 timestamp[31:0], w7..w63 zero.
// -----------------------------------------------------------------------------
module esm_status_reporter
  import esm_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH     = 32,
  parameter logic [7:0]  MODULE_ID          = 8'd0,
  parameter int          HEARTBEAT_INTERVAL = 1000
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                Enable_status,
  input  logic [1:0]                          Enable_channelizer,
  input  logic [1:0]                          Enable_pdw_encoder,
  input  esm_channelizer_warnings_t [1:0]     Channelizer_warnings,
  input  esm_channelizer_errors_t   [1:0]     Channelizer_errors,
  input  logic                                Axis_ready,
  output logic                                Axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]           Axis_data,
  output logic                                Axis_last
);

  // ---------------------------------------------------------------------------
  // Local types and constants
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0]  module_id;
    logic [7:0]  msg_type;
    logic [15:0] reserved;
  } report_header_t;

  localparam int             TIMER_W   = $clog2(HEARTBEAT_INTERVAL);
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(HEARTBEAT_INTERVAL - 1);
  localparam logic [5:0]     LAST_WORD = 6'(ESM_REPORT_WORDS - 1);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SEND = 1'b1;

  localparam report_header_t HEADER = '{
    module_id: MODULE_ID,
    msg_type:  esm_report_message_type_status,
    reserved:  16'h0
  };

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       state;
  logic                       pending;
  logic [5:0]                 word_idx;
  logic [TIMER_W-1:0]         hb_timer;
  logic [63:0]                timestamp;
  logic [31:0]                seq_cnt;
  logic [ESM_STATUS_BITS-1:0] sticky_flags;

  // Snapshot registers feeding the word mux; frozen for the whole packet.
  logic [31:0]                snap_seq;
  logic [4:0]                 snap_enables;
  logic [ESM_STATUS_BITS-1:0] snap_status;
  logic [63:0]                snap_timestamp;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic                       trigger;
  logic                       xfer;
  logic                       last_xfer;
  logic                       do_snapshot;
  logic [ESM_STATUS_BITS-1:0] status_in;

  // Trigger is high during the wrap cycle of the timer, so the snapshot lands
  // on the HEARTBEAT_INTERVAL-th edge after reset release.
  assign trigger   = Enable_status && (hb_timer == LAST_TICK);

  // Valid is a pure function of state, never of Axis_ready.
  assign Axis_valid = (state == STATE_SEND);
  assign xfer       = Axis_valid && Axis_ready;
  assign last_xfer  = xfer && (word_idx == LAST_WORD);

  // Snapshot either on a fresh trigger while idle, or on packet completion
  // when a trigger is waiting (pending now, or arriving this very cycle).
  assign do_snapshot = ((state == STATE_IDLE) && trigger) ||
                       (last_xfer && (pending || trigger));

  assign status_in = esm_pack_status(Channelizer_warnings, Channelizer_errors);

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignment so every always_ff reads
  // the pre-edge values of its peers regardless of evaluation order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= STATE_IDLE;
      pending        <= 1'b0;
      word_idx       <= '0;
      hb_timer       <= '0;
      timestamp      <= '0;
      seq_cnt        <= '0;
      sticky_flags   <= '0;
      snap_seq       <= '0;
      snap_enables   <= '0;
      snap_status    <= '0;
      snap_timestamp <= '0;
    end else begin
      timestamp <= timestamp + 64'd1;

      if (!Enable_status || (hb_timer == LAST_TICK)) begin
        hb_timer <= '0;
      end else begin
        hb_timer <= hb_timer + TIMER_W'(1);
      end

      // Pulses in the snapshot cycle go into this report and are not kept
      // for the next one.
      if (do_snapshot) begin
        snap_seq       <= seq_cnt;
        snap_enables   <= {Enable_pdw_encoder, Enable_channelizer, Enable_status};
        snap_status    <= sticky_flags | status_in;
        snap_timestamp <= timestamp;
        seq_cnt        <= seq_cnt + 32'd1;
        sticky_flags   <= '0;
      end else begin
        sticky_flags   <= sticky_flags | status_in;
      end

      // Six-bit index wraps 63 -> 0 on the final transfer.
      if (xfer) begin
        word_idx <= word_idx + 6'd1;
      end

      case (state)
        STATE_IDLE: begin
          if (trigger) begin
            state <= STATE_SEND;
          end
        end
        STATE_SEND: begin
          if (last_xfer) begin
            // A pending trigger is consumed by the back-to-back snapshot; if a
            // new trigger coincides with that, it becomes the next pending one.
            pending <= pending && trigger;
            if (!(pending || trigger)) begin
              state <= STATE_IDLE;
            end
          end else if (trigger) begin
            pending <= 1'b1;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word mux
  // ---------------------------------------------------------------------------
  logic [AXI_DATA_WIDTH-1:0] word_mux;

  // NOTE: word_mux gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    word_mux = '0;
    case (word_idx)
      6'd0: word_mux = esm_report_magic_num;
      6'd1: word_mux = snap_seq;
      6'd2: word_mux = HEADER;
      6'd3: word_mux = {27'b0, snap_enables};
      6'd4: word_mux = {{(32 - ESM_STATUS_BITS){1'b0}}, snap_status};
      6'd5: word_mux = snap_timestamp[63:32];
      6'd6: word_mux = snap_timestamp[31:0];
      default: word_mux = '0;
    endcase
  end

  // Data and last are zero while idle so the bus rests at its reset values.
  assign Axis_data = Axis_valid ? word_mux : '0;
  assign Axis_last = Axis_valid && (word_idx == LAST_WORD);

endmodule

// File: tb/tb_esm_status_reporter.sv
// -----------------------------------------------------------------------------
// tb_esm_status_reporter
// Self-checking bench for esm_status_reporter. Inputs are driven and outputs
// sampled on the falling edge. Expected packets are built from the report
// rules: header constants, enables and pulse subsets as driven, sequence
// numbers counted here, and the timestamp taken as the snapshot edge index
// minus one (the counter's value in the cycle before that edge).
// -----------------------------------------------------------------------------
module tb_esm_status_reporter;
  import esm_pkg::*;

  localparam int         HB     = 1000;
  localparam logic [7:0] MOD_ID = 8'h5A;

  logic                            Clk;
  logic                            Rst;
  logic                            Enable_status;
  logic [1:0]                      Enable_channelizer;
  logic [1:0]                      Enable_pdw_encoder;
  esm_channelizer_warnings_t [1:0] Channelizer_warnings;
  esm_channelizer_errors_t   [1:0] Channelizer_errors;
  logic                            Axis_ready;
  logic                            Axis_valid;
  logic [31:0]                     Axis_data;
  logic                            Axis_last;

  esm_status_reporter #(
    .AXI_DATA_WIDTH    (32),
    .MODULE_ID         (MOD_ID),
    .HEARTBEAT_INTERVAL(HB)
  ) dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .Enable_status       (Enable_status),
    .Enable_channelizer  (Enable_channelizer),
    .Enable_pdw_encoder  (Enable_pdw_encoder),
    .Channelizer_warnings(Channelizer_warnings),
    .Channelizer_errors  (Channelizer_errors),
    .Axis_ready          (Axis_ready),
    .Axis_valid          (Axis_valid),
    .Axis_data           (Axis_data),
    .Axis_last           (Axis_last)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Rising edges since reset release; edge 1 is the first edge with Rst low.
  int unsigned edge_cnt;
  always @(posedge Clk) begin
    if (Rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] seq_exp;

  // Watchdog: the whole run is far shorter than this.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit (checks=%0d passed=%0d)", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  // Reference status word from the bit map, one field at a time.
  function automatic logic [11:0] model_status(
    input esm_channelizer_warnings_t [1:0] w,
    input esm_channelizer_errors_t   [1:0] e
  );
    logic [11:0] s;
    s = '0;
    for (int c = 0; c < 2; c++) begin
      s[c]           = w[c].demux_gap;
      s[2 + 5*c + 0] = e[c].demux_overflow;
      s[2 + 5*c + 1] = e[c].filter_overflow;
      s[2 + 5*c + 2] = e[c].mux_overflow;
      s[2 + 5*c + 3] = e[c].mux_underflow;
      s[2 + 5*c + 4] = e[c].mux_collision;
    end
    return s;
  endfunction

  function automatic logic [4:0] cur_enables();
    return {Enable_pdw_encoder, Enable_channelizer, Enable_status};
  endfunction

  // One-cycle pulse on the warning/error inputs; returns the status it implies.
  task automatic inject(input logic [1:0] wb, input logic [9:0] eb, output logic [11:0] exp);
    esm_channelizer_warnings_t [1:0] wv;
    esm_channelizer_errors_t   [1:0] ev;
    wv = wb;
    ev = eb;
    exp = model_status(wv, ev);
    Channelizer_warnings = wv;
    Channelizer_errors   = ev;
    @(negedge Clk);
    Channelizer_warnings = '0;
    Channelizer_errors   = '0;
  endtask

  task automatic do_reset(input int cycles);
    Rst = 1'b1;
    repeat (cycles) @(negedge Clk);
    Rst = 1'b0;
    seq_exp = 32'd0;
  endtask

  // Receives one packet (entered on a falling edge) and compares every word.
  // snap_edge_in < 0: the snapshot edge is the edge before valid is first seen.
  task automatic collect_packet(
    input  string       name,
    input  int          ready_pct,
    input  logic [31:0] exp_seq,
    input  logic [4:0]  exp_en,
    input  logic [11:0] exp_status,
    input  int          snap_edge_in,
    input  bit          aligned,
    output int          done_edge,
    output int          snap_edge
  );
    logic [31:0] got_data [64];
    logic        got_last [64];
    logic [31:0] exp_word [64];
    logic [63:0] exp_ts;
    logic [31:0] held_data;
    logic        held_last;
    bit          stalled;
    bit          rdy;
    int          idx;
    int          cyc;

    done_edge = -1;
    snap_edge = -1;
    cyc = 0;
    while (Axis_valid !== 1'b1 && cyc < 3*HB) begin
      @(negedge Clk);
      cyc++;
    end
    n_checks++;
    if (Axis_valid !== 1'b1) begin
      $display("FAIL %s start: valid=%b after %0d cycles, required 1", name, Axis_valid, cyc);
      return;
    end
    n_pass++;

    snap_edge = (snap_edge_in >= 0) ? snap_edge_in : int'(edge_cnt);
    if (aligned) begin
      n_checks++;
      if ((snap_edge % HB) != 0)
        $display("FAIL %s trigger phase: snapshot edge %0d, required a multiple of %0d", name, snap_edge, HB);
      else
        n_pass++;
    end

    exp_ts = 64'(snap_edge - 1);
    for (int i = 0; i < 64; i++) exp_word[i] = 32'h0;
    exp_word[0] = esm_report_magic_num;
    exp_word[1] = exp_seq;
    exp_word[2] = {MOD_ID, esm_report_message_type_status, 16'h0};
    exp_word[3] = {27'b0, exp_en};
    exp_word[4] = {20'b0, exp_status};
    exp_word[5] = exp_ts[63:32];
    exp_word[6] = exp_ts[31:0];

    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (idx < 64 && cyc < 40*64) begin
      if (stalled) begin
        n_checks++;
        if (Axis_valid !== 1'b1 || Axis_data !== held_data || Axis_last !== held_last)
          $display("FAIL %s hold w%0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   name, idx, Axis_valid, Axis_data, Axis_last, held_data, held_last);
        else
          n_pass++;
      end
      rdy = ($urandom_range(99) < ready_pct);
      Axis_ready = rdy;
      if (Axis_valid === 1'b1 && rdy) begin
        got_data[idx] = Axis_data;
        got_last[idx] = Axis_last;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled   = (Axis_valid === 1'b1);
        held_data = Axis_data;
        held_last = Axis_last;
      end
      @(negedge Clk);
      cyc++;
    end
    done_edge = int'(edge_cnt);
    Axis_ready = 1'b1;

    n_checks++;
    if (idx != 64)
      $display("FAIL %s length: received %0d words, required 64", name, idx);
    else
      n_pass++;

    for (int i = 0; i < idx; i++) begin
      n_checks++;
      if (got_data[i] !== exp_word[i] || got_last[i] !== (i == 63))
        $display("FAIL %s w%0d: data=%h last=%b, required data=%h last=%b",
                 name, i, got_data[i], got_last[i], exp_word[i], (i == 63));
      else
        n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int done, snap;
    Enable_status        = 1'b1;
    Enable_channelizer   = 2'b00;
    Enable_pdw_encoder   = 2'b00;
    Channelizer_warnings = '0;
    Channelizer_errors   = '0;
    Axis_ready           = 1'b1;
    do_reset(5);
    n_checks++;
    if (Axis_valid !== 1'b0 || Axis_last !== 1'b0 || Axis_data !== 32'h0)
      $display("FAIL reset outputs: valid=%b last=%b data=%h, required 0 0 00000000",
               Axis_valid, Axis_last, Axis_data);
    else
      n_pass++;

    collect_packet("first", 100, 32'd0, 5'b00001, 12'h000, -1, 1'b1, done, snap);
    seq_exp++;
    n_checks++;
    if (snap != HB)
      $display("FAIL first trigger: snapshot edge %0d, required %0d", snap, HB);
    else
      n_pass++;
  endtask

  task automatic test_random_reports();
    int done, snap;
    logic [11:0] exp;
    do_reset(3);
    for (int i = 0; i < 20; i++) begin
      Enable_channelizer = 2'($urandom_range(3));
      Enable_pdw_encoder = 2'($urandom_range(3));
      inject(2'($urandom_range(3)), 10'($urandom_range(1023)), exp);
      collect_packet("random_report", 100, seq_exp, cur_enables(), exp, -1, 1'b1, done, snap);
      seq_exp++;
    end
  endtask

  task automatic test_random_ready();
    int done, snap;
    logic [11:0] exp;
    for (int i = 0; i < 3; i++) begin
      Enable_channelizer = 2'($urandom_range(3));
      Enable_pdw_encoder = 2'($urandom_range(3));
      inject(2'($urandom_range(3)), 10'($urandom_range(1023)), exp);
      collect_packet("random_ready", 80, seq_exp, cur_enables(), exp, -1, 1'b1, done, snap);
      seq_exp++;
    end
  endtask

  task automatic test_coincident_pulse();
    int done, snap, cyc;
    logic [11:0] exp;
    cyc = 0;
    while ((edge_cnt % HB) != HB - 1 && cyc < 2*HB) begin
      @(negedge Clk);
      cyc++;
    end
    // Pulse is sampled on the snapshot edge itself.
    inject(2'($urandom_range(1, 3)), 10'($urandom_range(1, 1023)), exp);
    collect_packet("coincident", 100, seq_exp, cur_enables(), exp, -1, 1'b1, done, snap);
    seq_exp++;
    collect_packet("after_coincident", 100, seq_exp, cur_enables(), 12'h000, -1, 1'b1, done, snap);
    seq_exp++;
  endtask

  task automatic test_back_to_back();
    int done, snap, first_snap, cyc;
    bit saw_valid;
    Axis_ready = 1'b0;
    cyc = 0;
    while (Axis_valid !== 1'b1 && cyc < 2*HB) begin
      @(negedge Clk);
      cyc++;
    end
    first_snap = int'(edge_cnt);
    repeat (1500) begin
      Axis_ready = 1'b0;
      @(negedge Clk);
    end
    collect_packet("stalled", 100, seq_exp, cur_enables(), 12'h000, first_snap, 1'b1, done, snap);
    seq_exp++;
    n_checks++;
    if (Axis_valid !== 1'b1)
      $display("FAIL back_to_back start: valid=%b right after w63, required 1", Axis_valid);
    else
      n_pass++;
    collect_packet("pending", 100, seq_exp, cur_enables(), 12'h000, done, 1'b0, done, snap);
    seq_exp++;
    saw_valid = 1'b0;
    repeat (200) begin
      if (Axis_valid === 1'b1) saw_valid = 1'b1;
      @(negedge Clk);
    end
    n_checks++;
    if (saw_valid)
      $display("FAIL no_third: valid=1 seen within 200 cycles, required 0");
    else
      n_pass++;
  endtask

  task automatic test_enable_off();
    int done, snap, cyc;
    bit saw_valid;
    cyc = 0;
    while (Axis_valid !== 1'b1 && cyc < 2*HB) begin
      @(negedge Clk);
      cyc++;
    end
    snap = int'(edge_cnt);
    Enable_status = 1'b0;
    collect_packet("enable_off", 100, seq_exp, {cur_enables()} | 5'b00001, 12'h000, snap, 1'b1, done, snap);
    seq_exp++;
    saw_valid = 1'b0;
    repeat (5*HB/2) begin
      if (Axis_valid === 1'b1) saw_valid = 1'b1;
      @(negedge Clk);
    end
    n_checks++;
    if (saw_valid)
      $display("FAIL disabled: valid=1 seen while Enable_status=0, required 0");
    else
      n_pass++;
    Enable_status = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    int done, snap, cyc;
    logic [11:0] exp;
    cyc = 0;
    while (Axis_valid !== 1'b1 && cyc < 2*HB) begin
      @(negedge Clk);
      cyc++;
    end
    repeat (10) @(negedge Clk);
    // This pulse would show up in the next report if reset did not clear it.
    inject(2'($urandom_range(1, 3)), 10'($urandom_range(1, 1023)), exp);
    Rst = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (Axis_valid !== 1'b0 || Axis_last !== 1'b0 || Axis_data !== 32'h0)
      $display("FAIL mid_reset outputs: valid=%b last=%b data=%h, required 0 0 00000000",
               Axis_valid, Axis_last, Axis_data);
    else
      n_pass++;
    do_reset(99);
    collect_packet("after_reset", 100, seq_exp, cur_enables(), 12'h000, -1, 1'b1, done, snap);
    seq_exp++;
    n_checks++;
    if (snap != HB)
      $display("FAIL after_reset trigger: snapshot edge %0d, required %0d", snap, HB);
    else
      n_pass++;
  endtask

  initial begin
    Rst                  = 1'b1;
    Enable_status        = 1'b1;
    Enable_channelizer   = '0;
    Enable_pdw_encoder   = '0;
    Channelizer_warnings = '0;
    Channelizer_errors   = '0;
    Axis_ready           = 1'b1;
    seq_exp              = '0;
    @(negedge Clk);

    test_reset();
    test_random_reports();
    test_random_ready();
    test_coincident_pulse();
    test_back_to_back();
    test_enable_off();
    test_reset_mid_packet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
